// File: rtl/scope_capture_ctrl.sv
// scope_capture_ctrl: oscilloscope trigger/capture sequencer that writes DEPTH samples into a buffer
// starting at a rising threshold crossing, or at a forced trigger in auto mode.
module scope_capture_ctrl #(
    parameter int DATA_W  = 12,
    parameter int ADDR_W  = 10,
    parameter int AUTO_TO = 1000
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              SAMPLE_EN,
    input  logic [DATA_W-1:0] SAMPLE,
    input  logic [DATA_W-1:0] TRIG_LEVEL,
    input  logic              AUTO,
    input  logic              ARM,
    input  logic              ABORT,
    output logic              WR_EN,
    output logic [ADDR_W-1:0] WR_ADDR,
    output logic [DATA_W-1:0] WR_DATA,
    output logic              BUSY,
    output logic              DONE,
    output logic              TRIGGERED
);
    localparam int TW = $clog2(AUTO_TO + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(AUTO_TO - 1);
    localparam logic [ADDR_W-1:0] LAST = '1;

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] prev, prev_n, wr_data_n;
    logic [ADDR_W-1:0] wr_addr_n, addr_inc;
    logic [TW-1:0]     tmo, tmo_n;
    logic              prev_valid, prev_valid_n, wr_en_n, trig_n;
    logic              crossing, timeout;

    assign addr_inc = WR_ADDR + 1'b1;
    assign crossing = SAMPLE_EN && prev_valid && (prev < TRIG_LEVEL) && (SAMPLE >= TRIG_LEVEL);
    assign timeout  = SAMPLE_EN && AUTO && (tmo == TMO_MAX);

    always_comb begin
        state_n      = state;
        prev_n       = prev;
        prev_valid_n = prev_valid;
        tmo_n        = tmo;
        wr_en_n      = 1'b0;
        wr_addr_n    = WR_ADDR;
        wr_data_n    = WR_DATA;
        trig_n       = TRIGGERED;
        case (state)
            S_IDLE, S_DONE: begin
                if (ARM) begin
                    state_n      = S_ARMED;
                    prev_valid_n = 1'b0;
                    tmo_n        = '0;
                end
            end
            S_ARMED: begin
                if (SAMPLE_EN) begin
                    prev_n       = SAMPLE;
                    prev_valid_n = 1'b1;
                    if (crossing || timeout) begin
                        state_n   = S_CAPTURE;
                        trig_n    = crossing;
                        wr_en_n   = 1'b1;
                        wr_addr_n = '0;
                        wr_data_n = SAMPLE;
                    end else if (tmo != TMO_MAX) begin
                        tmo_n = tmo + 1'b1;
                    end
                end
            end
            S_CAPTURE: begin
                if (SAMPLE_EN) begin
                    wr_en_n   = 1'b1;
                    wr_addr_n = addr_inc;
                    wr_data_n = SAMPLE;
                    if (addr_inc == LAST) state_n = S_DONE;
                end
            end
            default: state_n = S_IDLE;
        endcase
        // abort overrides everything decided above, including a same-cycle trigger
        if (ABORT) begin
            state_n   = S_IDLE;
            wr_en_n   = 1'b0;
            wr_addr_n = WR_ADDR;
            wr_data_n = WR_DATA;
            trig_n    = TRIGGERED;
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state      <= S_IDLE;
            prev       <= '0;
            prev_valid <= 1'b0;
            tmo        <= '0;
            WR_EN      <= 1'b0;
            WR_ADDR    <= '0;
            WR_DATA    <= '0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            TRIGGERED  <= 1'b0;
        end else begin
            state      <= state_n;
            prev       <= prev_n;
            prev_valid <= prev_valid_n;
            tmo        <= tmo_n;
            WR_EN      <= wr_en_n;
            WR_ADDR    <= wr_addr_n;
            WR_DATA    <= wr_data_n;
            BUSY       <= (state_n == S_ARMED) || (state_n == S_CAPTURE);
            DONE       <= (state_n == S_DONE);
            TRIGGERED  <= trig_n;
        end
    end
endmodule

// File: tb/tb_scope_capture_ctrl.sv
// tb_scope_capture_ctrl: directed and randomized captures checked against a sample-list trigger model.
module tb_scope_capture_ctrl;
    localparam int DW = 12, AW = 4, TO = 5, DEPTH = 16;

    logic          CLOCK = 1'b0, RESET = 1'b0, SAMPLE_EN = 1'b0, AUTO = 1'b0, ARM = 1'b0, ABORT = 1'b0;
    logic [DW-1:0] SAMPLE = '0, TRIG_LEVEL = '0;
    logic          WR_EN, BUSY, DONE, TRIGGERED;
    logic [AW-1:0] WR_ADDR;
    logic [DW-1:0] WR_DATA;

    int          tests = 0, fails = 0, cyc = 0;
    logic [47:0] obs[$];
    int          stim[$];
    int          scyc[$];

    scope_capture_ctrl #(.DATA_W(DW), .ADDR_W(AW), .AUTO_TO(TO)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .SAMPLE_EN(SAMPLE_EN), .SAMPLE(SAMPLE),
        .TRIG_LEVEL(TRIG_LEVEL), .AUTO(AUTO), .ARM(ARM), .ABORT(ABORT),
        .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
        .BUSY(BUSY), .DONE(DONE), .TRIGGERED(TRIGGERED)
    );

    always #5 CLOCK = ~CLOCK;
    always @(posedge CLOCK) cyc <= cyc + 1;
    always @(negedge CLOCK) if (WR_EN === 1'b1) obs.push_back({cyc, WR_ADDR, WR_DATA});

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLOCK);
        #1;
    endtask

    // trigger index within the presented sample list: first rising crossing, else the forced one
    function automatic int trig_idx(input int lvl, input bit auto_m, output bit real_x);
        real_x = 1'b0;
        for (int i = 0; i < stim.size(); i++) begin
            if (i > 0 && stim[i-1] < lvl && stim[i] >= lvl) begin
                real_x = 1'b1;
                return i;
            end
            if (auto_m && i == TO - 1) return i;
        end
        return -1;
    endfunction

    task automatic run(input string tag, input int lvl, input bit auto_m, input int gap_max);
        int t, n;
        bit rx, prev_trig;
        prev_trig  = TRIGGERED;
        TRIG_LEVEL = DW'(lvl);
        AUTO       = auto_m;
        ARM        = 1'b1;
        tick;
        ARM = 1'b0;
        obs.delete();
        scyc.delete();
        foreach (stim[i]) begin
            repeat ($urandom_range(0, gap_max)) begin
                SAMPLE = DW'($urandom);
                tick;
            end
            SAMPLE_EN = 1'b1;
            SAMPLE    = DW'(stim[i]);
            scyc.push_back(cyc);
            tick;
            SAMPLE_EN = 1'b0;
        end
        tick;
        tick;
        @(negedge CLOCK);
        t = trig_idx(lvl, auto_m, rx);
        n = (t < 0) ? 0 : ((stim.size() - t < DEPTH) ? stim.size() - t : DEPTH);
        chk({tag, " nwr"}, obs.size(), n);
        for (int k = 0; k < n && k < obs.size(); k++)
            chk({tag, " wr"}, obs[k], {scyc[t+k] + 1, AW'(k), DW'(stim[t+k])});
        chk({tag, " done"}, DONE, n == DEPTH);
        chk({tag, " busy"}, BUSY, n != DEPTH);
        chk({tag, " trig"}, TRIGGERED, (t < 0) ? prev_trig : rx);
        ABORT = 1'b1;
        tick;
        ABORT = 1'b0;
        @(negedge CLOCK);
        chk({tag, " abort"}, {BUSY, DONE, TRIGGERED}, {2'b00, (t < 0) ? prev_trig : rx});
    endtask

    initial begin
        int n0;
        bit found;
        #1 RESET = 1'b1;
        #2 chk("reset outs", {WR_EN, WR_ADDR, WR_DATA, BUSY, DONE, TRIGGERED}, '0);
        #20 RESET = 1'b0;
        tick;

        stim = '{'h700, 'h900};
        repeat (15) stim.push_back($urandom_range(0, 4095));
        run("cross", 'h800, 1'b0, 0);

        stim = '{'h900, 'h100, 'h900};
        repeat (15) stim.push_back($urandom_range(0, 4095));
        run("first", 'h800, 1'b0, 0);

        stim.delete();
        repeat (20) stim.push_back(0);
        run("auto", 'h800, 1'b1, 1);

        for (int r = 0; r < 10; r++) begin
            stim.delete();
            repeat (24) stim.push_back($urandom_range(0, 4095));
            run("rand", $urandom_range(1, 4095), 1'($urandom), 2);
        end

        obs.delete();
        ARM   = 1'b1;
        ABORT = 1'b1;
        tick;
        ARM   = 1'b0;
        ABORT = 1'b0;
        @(negedge CLOCK);
        chk("arm+abort", {BUSY, DONE}, 2'b00);
        TRIG_LEVEL = 'h800;
        AUTO       = 1'b0;
        SAMPLE_EN  = 1'b1;
        SAMPLE     = 'h700;
        tick;
        SAMPLE = 'h900;
        tick;
        SAMPLE_EN = 1'b0;
        tick;
        @(negedge CLOCK);
        chk("arm+abort nwr", obs.size(), 0);

        obs.delete();
        ARM = 1'b1;
        tick;
        ARM       = 1'b0;
        SAMPLE_EN = 1'b1;
        foreach (stim[i]) stim[i] = 0;
        stim = '{'h700, 'h900, 'h111, 'h222};
        foreach (stim[i]) begin
            SAMPLE = DW'(stim[i]);
            tick;
        end
        SAMPLE = 'h333;
        ABORT  = 1'b1;
        tick;
        ABORT = 1'b0;
        repeat (2) tick;
        SAMPLE_EN = 1'b0;
        tick;
        @(negedge CLOCK);
        chk("cap abort nwr", obs.size(), 3);
        if (obs.size() >= 3) chk("cap abort last", obs[2][15:0], {4'd2, 12'h222});
        chk("cap abort idle", {BUSY, DONE}, 2'b00);

        obs.delete();
        found = 1'b0;
        ARM   = 1'b1;
        tick;
        ARM       = 1'b0;
        SAMPLE_EN = 1'b1;
        SAMPLE    = 'h700;
        tick;
        for (int i = 0; i < 40 && !found; i++) begin
            SAMPLE = (i == 0) ? DW'('h900) : DW'($urandom);
            tick;
            @(negedge CLOCK);
            found = (WR_EN === 1'b1) && (WR_ADDR == 4'd7);
        end
        chk("rst addr7 seen", found, 1'b1);
        #2 RESET = 1'b1;
        #1 chk("rst async outs", {WR_EN, WR_ADDR, WR_DATA, BUSY, DONE, TRIGGERED}, '0);
        #1 RESET = 1'b0;
        n0 = obs.size();
        repeat (20) begin
            SAMPLE = DW'($urandom);
            tick;
        end
        SAMPLE_EN = 1'b0;
        @(negedge CLOCK);
        chk("rst no writes", obs.size(), n0);
        chk("rst idle", {BUSY, DONE}, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
